// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-path types: RAM handshake state, data word and arbiter FSM state.
// Latency: n/a (types only).
// Backpressure: n/a. arb_state_t is kept here so debug/trace logic can decode the arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM model handshake state.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arbiter_if.sv
// Bundle of the instruction/data request channels and the single RAM port.
// Latency: n/a (wiring only).
// Backpressure: iwait/dwait stay high until the RAM completes the granted access.
// Modports: arb = arbiter view (requests and RAM responses in, RAM controls out),
//           ram = RAM model view.
interface arbiter_if;
  import cpu_types_pkg::*;

  // instruction fetch channel
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // load/store channel
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM port
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter: data requests win, a starvation counter forces a fetch after STARVE_MAX data grants.
// Latency: request seen at edge N drives the RAM in cycle N+1; completes in cycle N+1+L for L busy cycles.
// Backpressure: requester holds its request/address/data while its wait is high; wait drops only in the completing cycle.
// Ports: CLK, nRST (async active-low), bus (arbiter_if.arb: iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload,
//        ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate), err (sticky RAM error flag).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4  // 1..15
) (
  input  logic      CLK,
  input  logic      nRST,
  arbiter_if.arb    bus,
  output logic      err
);

  arb_state_t  state, next_state;
  logic [3:0]  starve_cnt, next_cnt;
  logic        next_err;
  logic        d_req;
  logic        force_i;

  // dREN together with dWEN is a write; either one is a data request.
  assign d_req   = bus.dREN | bus.dWEN;
  assign force_i = bus.iREN & (starve_cnt == 4'(STARVE_MAX));

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
      err        <= next_err;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = starve_cnt;
    next_err     = err;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = bus.ramload;
    bus.dload    = bus.ramload;

    case (state)
      IDLE: begin
        if (d_req && !force_i) begin
          next_state = DACC;
          // force_i is low here, so with iREN high the counter is below
          // STARVE_MAX and the increment cannot pass the saturation point.
          if (bus.iREN) next_cnt = starve_cnt + 4'd1;
        end else if (bus.iREN) begin
          next_state = IACC;
          next_cnt   = '0;
        end
        if (!bus.iREN) next_cnt = '0;
      end

      IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (bus.ramstate == ERROR) next_err = 1'b1;
        // A dropped request (halt/flush) abandons the access silently.
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait  = 1'b0;
          next_state = IDLE;
        end
      end

      DACC: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = ~bus.dWEN;
        if (bus.ramstate == ERROR) next_err = 1'b1;
        if (!d_req) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait  = 1'b0;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The RAM model returns ramload = ramaddr ^ KEY so every completion carries a predictable word.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam word_t KEY = 32'h2402_004A;

  typedef struct {
    logic  is_data;
    word_t load;
  } exp_t;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  err;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];

  arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus),
    .err  (err)
  );

  always #5 CLK = ~CLK;

  assign bus.ramload = bus.ramaddr ^ KEY;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    nRST = 1'b0;
    #3;
    check("rst_state",   32'(dut.state),      32'(IDLE));
    check("rst_starve",  32'(dut.starve_cnt), 32'd0);
    check("rst_err",     32'(err),            32'd0);
    check("rst_ramREN",  32'(bus.ramREN),     32'd0);
    check("rst_ramWEN",  32'(bus.ramWEN),     32'd0);
    check("rst_iwait",   32'(bus.iwait),      32'd1);
    check("rst_dwait",   32'(bus.dwait),      32'd1);
    check("rst_ramaddr", bus.ramaddr,         32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  // Scoreboard: every completion pulse must match the oldest expected one.
  always @(negedge CLK) begin : monitor
    exp_t e;
    logic is_d;
    if (nRST === 1'b1 && (bus.iwait === 1'b0 || bus.dwait === 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {30'd0, bus.iwait, bus.dwait}, 32'd3);
      end else begin
        e    = sb.pop_front();
        is_d = (bus.dwait === 1'b0);
        check("done_kind", 32'(is_d), 32'(e.is_data));
        check("done_load", is_d ? bus.dload : bus.iload, e.load);
        check("done_single", {30'd0, bus.iwait, bus.dwait}, is_d ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dgrants;
    dgrants = 0;

    // Lone fetch, immediate ACCESS
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = ACCESS;
    sb.push_back('{is_data: 1'b0, load: 32'h2402_000A});
    sample();
    check("t1_c0_ramREN", 32'(bus.ramREN), 32'd0);
    check("t1_c0_iwait",  32'(bus.iwait),  32'd1);
    step(); sample();
    check("t1_c1_ramREN",  32'(bus.ramREN), 32'd1);
    check("t1_c1_ramaddr", bus.ramaddr,     32'h40);
    check("t1_c1_iwait",   32'(bus.iwait),  32'd0);
    check("t1_c1_iload",   bus.iload,       32'h2402_000A);
    step();
    bus.iREN = 1'b0;
    check("t1_e2_state", 32'(dut.state), 32'(IDLE));
    sample();
    check("t1_c2_iwait",  32'(bus.iwait),  32'd1);
    check("t1_c2_ramREN", 32'(bus.ramREN), 32'd0);

    // Contention: data first, then fetch after one IDLE bubble
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = ACCESS;
    sb.push_back('{is_data: 1'b1, load: 32'h100 ^ KEY});
    sb.push_back('{is_data: 1'b0, load: 32'h40 ^ KEY});
    step(); sample();
    check("t2_c1_state",   32'(dut.state), 32'(DACC));
    check("t2_c1_ramaddr", bus.ramaddr,    32'h100);
    check("t2_c1_iwait",   32'(bus.iwait), 32'd1);
    step();
    bus.dREN = 1'b0;
    sample();
    check("t2_c2_state",  32'(dut.state),  32'(IDLE));
    check("t2_c2_ramREN", 32'(bus.ramREN), 32'd0);
    step(); sample();
    check("t2_c3_state",   32'(dut.state), 32'(IACC));
    check("t2_c3_ramaddr", bus.ramaddr,    32'h40);
    step();
    bus.iREN = 1'b0;

    // Starvation bound: four data grants, then a forced fetch
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = ACCESS;
    for (int k = 0; k < 4; k++) sb.push_back('{is_data: 1'b1, load: 32'h100 ^ KEY});
    sb.push_back('{is_data: 1'b0, load: 32'h40 ^ KEY});
    for (int c = 1; c <= 9; c++) begin
      step(); sample();
      if (dut.state == DACC) dgrants++;
      if (c == 8) check("t3_starve_sat", 32'(dut.starve_cnt), 32'd4);
      if (c == 9) check("t3_forced_iacc", 32'(dut.state), 32'(IACC));
    end
    check("t3_dgrants", 32'(dgrants), 32'd4);
    step();
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    sample();
    check("t3_starve_clr", 32'(dut.starve_cnt), 32'd0);

    // Write with three BUSY cycles
    do_reset();
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF; bus.ramstate = BUSY;
    sb.push_back('{is_data: 1'b1, load: 32'h200 ^ KEY});
    for (int c = 1; c <= 4; c++) begin
      step();
      bus.ramstate = (c == 4) ? ACCESS : BUSY;
      sample();
      check("t4_ramWEN",   32'(bus.ramWEN), 32'd1);
      check("t4_ramREN",   32'(bus.ramREN), 32'd0);
      check("t4_ramaddr",  bus.ramaddr,     32'h200);
      check("t4_ramstore", bus.ramstore,    32'hDEAD_BEEF);
      check("t4_dwait",    32'(bus.dwait),  (c == 4) ? 32'd0 : 32'd1);
    end
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    sample();
    check("t4_after_ramWEN", 32'(bus.ramWEN), 32'd0);

    // ERROR during DACC, then withdraw
    do_reset();
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ERROR;
    step(); sample();
    check("t5_c1_state", 32'(dut.state), 32'(DACC));
    check("t5_c1_dwait", 32'(bus.dwait), 32'd1);
    step();
    bus.dREN = 1'b0;
    sample();
    check("t5_c2_err",   32'(err),       32'd1);
    check("t5_c2_dwait", 32'(bus.dwait), 32'd1);
    step();
    bus.ramstate = ACCESS;
    sample();
    check("t5_c3_state", 32'(dut.state), 32'(IDLE));
    check("t5_c3_err",   32'(err),       32'd1);
    repeat (3) step();
    sample();
    check("t5_err_sticky", 32'(err), 32'd1);

    // Reset asserted in the middle of a fetch
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = ERROR;
    step(); sample();
    check("t6_c1_ramREN", 32'(bus.ramREN), 32'd1);
    step();
    bus.ramstate = BUSY;
    sample();
    check("t6_c2_err", 32'(err), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("t6_rst_ramREN", 32'(bus.ramREN),  32'd0);
    check("t6_rst_iwait",  32'(bus.iwait),   32'd1);
    check("t6_rst_err",    32'(err),         32'd0);
    check("t6_rst_state",  32'(dut.state),   32'(IDLE));
    bus.iREN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
    step(); sample();
    check("t6_post_state", 32'(dut.state), 32'(IDLE));
    check("t6_post_iwait", 32'(bus.iwait), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-ported RAM arbiter between the instruction and data request channels of the processor's memory path. Sits between the cache/datapath side (instruction fetch and load/store requests) and the RAM model, holding a granted request until the RAM reports completion. Data requests get priority, and a starvation counter bounds how long fetch can be locked out. This lets the datapath and a future multicycle or pipelined core share one RAM port.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced next; range 1..15.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly the completing cycle of a fetch.
- iload  out  32  fetched instruction; valid when iwait low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN together is treated as a write.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the completing cycle of a data access.
- dload  out  32  read data; valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky; set when ramstate is ERROR during a granted access.

## Operation
- States: IDLE, IACC, DACC.
- IDLE → DACC when (dREN|dWEN) and not force_i. Otherwise IDLE → IACC when iREN. Otherwise stay in IDLE.
- force_i = iREN & (starve_cnt == STARVE_MAX).
- starve_cnt (4-bit):
  - Increments on each IDLE→DACC transition while iREN is high, saturating at STARVE_MAX.
  - Clears on IDLE→IACC.
  - Clears whenever iREN is low in IDLE.
- In IACC:
  - ramREN=1, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 and the next state is IDLE.
- In DACC:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0. Otherwise ramREN=1.
  - When ramstate==ACCESS: dwait=0 and the next state is IDLE.
- FREE/BUSY in an ACC state: hold the state with wait high.
- ERROR in an ACC state:
  - Set err.
  - Hold the state with wait high; the access retries until ACCESS.
- Request withdrawn mid-access (enable drops while in its ACC state): return to IDLE next edge with no wait pulse. This covers a halt or flush.
- iload and dload are combinational copies of ramload. Outside IACC and DACC, ram enables are 0, ramaddr=0 and ramstore=0.
- iwait=1 and dwait=1 in every cycle except the completing cycle.
- Addresses and data pass through unchanged; the block does no alignment checks.

## Timing
- Reset values:
  - state IDLE, starve_cnt 0, err 0.
  - ramREN/ramWEN 0.
  - iwait 1, dwait 1.
- Minimum latency: request seen in IDLE at edge N, RAM driven in cycle N+1.
  - With ACCESS in cycle N+1, wait is low in cycle N+1 and the state returns to IDLE at edge N+2.
  - Back-to-back grants therefore have one IDLE bubble.
- A RAM with L busy cycles completes in cycle N+1+L.
- A requester must keep its address and data stable while its wait is high. The arbiter does not register them.
- Simultaneous iREN and dREN in IDLE: data wins unless force_i.
- Reset asserted mid-access: immediate return to IDLE, enables drop asynchronously, and no completion pulse is produced.

## Structure
- ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t come from cpu_types_pkg.
- arb_state_t (IDLE, IACC, DACC) goes in cpu_types_pkg so the future pipelined core's debug and trace can decode it.
- Add an arbiter_if interface header matching the existing *_if.vh style, with modports arb and ram.
- No sub-modules. Use one registered FSM plus the starvation counter, with combinational output logic.

## Test plan
- Lone fetch:
  - Stimulus: iREN=1, iaddr=0x40, RAM returns ACCESS immediately with ramload=0x2402000A.
  - Required: ramREN=1 and ramaddr=0x40 in cycle 1; iwait=0 with iload=0x2402000A in cycle 1 only; state IDLE at edge 2.
- Contention:
  - Stimulus: iREN and dREN both high at 0x40 and 0x100.
  - Required: data is granted first. Fetch is granted after the data completion plus one IDLE cycle.
- Starvation, with STARVE_MAX=4:
  - Stimulus: iREN held high, dREN re-asserted continuously.
  - Required: exactly 4 data grants, then an IACC grant. starve_cnt reads 0 after the fetch.
- Write with 3 BUSY cycles:
  - Stimulus: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, RAM gives BUSY×3 then ACCESS.
  - Required: ramWEN=1 for 4 cycles with stable address and data; dwait low only in the 4th cycle.
- Error and withdraw:
  - Stimulus: ramstate=ERROR during DACC, then dREN dropped.
  - Required: err=1 and stays set; state IDLE next edge; dwait never goes low.
- Mid-access reset:
  - Stimulus: nRST pulsed low during IACC.
  - Required: ramREN=0 immediately, iwait=1, err=0, state IDLE.
